// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline inter-stage registers: occupancy
// encoding, per-boundary bundle widths and the EX/MEM data field layout.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_state_t;

  localparam int IF_ID_CTRL_W  = 1;
  localparam int IF_ID_DATA_W  = 64;
  localparam int ID_EX_CTRL_W  = 9;
  localparam int ID_EX_DATA_W  = 111;
  localparam int EX_MEM_CTRL_W = 4;
  localparam int EX_MEM_DATA_W = 69;
  localparam int MEM_WB_CTRL_W = 2;
  localparam int MEM_WB_DATA_W = 69;

  // EX/MEM data layout: {rd, store data, ALU result}
  localparam int EX_MEM_ALU_LSB   = 0;
  localparam int EX_MEM_ALU_W     = 32;
  localparam int EX_MEM_STORE_LSB = 32;
  localparam int EX_MEM_STORE_W   = 32;
  localparam int EX_MEM_RD_LSB    = 64;
  localparam int EX_MEM_RD_W      = 5;

  function automatic occ_state_t occupancy(input logic main_v, input logic skid_v);
    if (skid_v)      return ST_TWO;
    else if (main_v) return ST_ONE;
    else             return ST_EMPTY;
  endfunction

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter with synchronous clear, shared by performance counters.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  always_ff @(posedge clk) begin
    if (clr)
      value <= '0;
    else if (inc && (value != '1))
      value <= value + CNT_ONE;
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake, 2-entry skid
// buffer, flush-to-bubble and a saturating stall-cycle counter.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W         = EX_MEM_CTRL_W,
  parameter int DATA_W         = EX_MEM_DATA_W,
  parameter int CNT_W          = 16,
  parameter bit FLUSH_CLR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              r,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  occ_state_t state;
  logic       accept;
  logic       drain;

  assign state = occupancy(main_valid, skid_valid);

  // in_ready comes only from state and reset, so out_ready never reaches it
  assign in_ready  = ~skid_valid & ~r;
  assign accept    = in_valid & in_ready;
  assign drain     = main_valid & out_ready;

  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_data  = main_data;

  always_ff @(posedge clk) begin
    if (r) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      if (FLUSH_CLR_DATA) begin
        main_data <= '0;
        skid_data <= '0;
      end
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_valid <= 1'b1;
            main_ctrl  <= in_ctrl;
            main_data  <= in_data;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end else if (accept) begin
            skid_valid <= 1'b1;
            skid_ctrl  <= in_ctrl;
            skid_data  <= in_data;
          end else if (drain) begin
            main_valid <= 1'b0;
          end
        end
        ST_TWO: begin
          // Skid is always older than any new input, so it refills main first
          if (drain) begin
            main_ctrl  <= skid_ctrl;
            main_data  <= skid_data;
            skid_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .clr  (r),
    .inc  (main_valid & ~out_ready),
    .value(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Drives two pipe_skid_reg variants (flush clears data / keeps data) from one
// stimulus stream and compares both against a queue-based reference model.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        r = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_ctrl = '0;
  logic [68:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic        a_in_ready, a_out_valid;
  logic [3:0]  a_out_ctrl;
  logic [68:0] a_out_data;
  logic [3:0]  a_stall_cnt;
  logic        b_in_ready, b_out_valid;
  logic [3:0]  b_out_ctrl;
  logic [68:0] b_out_data;
  logic [15:0] b_stall_cnt;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  logic [72:0] q[$];
  int  cnt_a = 0;
  int  cnt_b = 0;
  bit  zero_a = 1'b0;
  bit  zero_b = 1'b0;
  bit  known = 1'b0;

  always #5 clk = ~clk;

  pipe_skid_reg #(
    .CTRL_W(4), .DATA_W(69), .CNT_W(4), .FLUSH_CLR_DATA(1'b1)
  ) dut_a (
    .clk(clk), .r(r), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_ctrl(a_out_ctrl),
    .out_data(a_out_data), .stall_cnt(a_stall_cnt)
  );

  pipe_skid_reg #(
    .CTRL_W(4), .DATA_W(69), .CNT_W(16), .FLUSH_CLR_DATA(1'b0)
  ) dut_b (
    .clk(clk), .r(r), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_ctrl(b_out_ctrl),
    .out_data(b_out_data), .stall_cnt(b_stall_cnt)
  );

  task automatic check(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input logic rr);
    logic [72:0] head;
    logic        exp_v;
    logic        exp_rdy;
    logic [3:0]  exp_ctrl;
    logic [68:0] exp_data;
    exp_v    = (q.size() > 0);
    head     = exp_v ? q[0] : '0;
    exp_rdy  = !rr && (q.size() < 2);
    exp_ctrl = exp_v ? head[72:69] : 4'h0;
    exp_data = head[68:0];
    check("a_in_ready", 69'(a_in_ready), 69'(exp_rdy));
    check("b_in_ready", 69'(b_in_ready), 69'(exp_rdy));
    check("a_out_valid", 69'(a_out_valid), 69'(exp_v));
    check("b_out_valid", 69'(b_out_valid), 69'(exp_v));
    check("a_out_ctrl", 69'(a_out_ctrl), 69'(exp_ctrl));
    check("b_out_ctrl", 69'(b_out_ctrl), 69'(exp_ctrl));
    if (exp_v) begin
      check("a_out_data", a_out_data, exp_data);
      check("b_out_data", b_out_data, exp_data);
    end else begin
      if (zero_a) check("a_out_data_zero", a_out_data, 69'h0);
      if (zero_b) check("b_out_data_zero", b_out_data, 69'h0);
    end
    check("a_stall_cnt", 69'(a_stall_cnt), 69'(cnt_a));
    check("b_stall_cnt", 69'(b_stall_cnt), 69'(cnt_b));
  endtask

  // One clock of stimulus: check current outputs, then advance DUTs and model
  task automatic apply_stimulus(input logic rr, input logic fl, input logic iv,
                                input logic [3:0] ic, input logic [68:0] id,
                                input logic orr);
    bit acc;
    r = rr; flush = fl; in_valid = iv; in_ctrl = ic; in_data = id; out_ready = orr;
    #1;
    if (known) check_output(rr);
    acc = iv && !rr && (q.size() < 2);
    @(posedge clk);
    #1;
    if (rr) begin
      q.delete();
      cnt_a = 0; cnt_b = 0;
      zero_a = 1'b1; zero_b = 1'b1;
      known = 1'b1;
    end else begin
      if (q.size() > 0 && !orr) begin
        if (cnt_a < 15) cnt_a++;
        if (cnt_b < 65535) cnt_b++;
      end
      if (q.size() > 0 && orr) void'(q.pop_front());
      if (fl) begin
        q.delete();
        zero_a = 1'b1;
      end else if (acc) begin
        q.push_back({ic, id});
        zero_a = 1'b0;
        zero_b = 1'b0;
      end
    end
  endtask

  task automatic idle(input logic orr, input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 4'h0, 69'h0, orr);
  endtask

  initial begin
    logic [95:0] rnd;

    apply_stimulus(1'b1, 1'b0, 1'b1, 4'hF, 69'h1234, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b1, 4'hF, 69'h1234, 1'b0);
    idle(1'b1, 1);

    for (int i = 1; i <= 8; i++)
      apply_stimulus(1'b0, 1'b0, 1'b1, 4'h3, 69'(i), 1'b1);
    idle(1'b1, 2);

    apply_stimulus(1'b0, 1'b0, 1'b1, 4'h5, 69'hA, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 4'h5, 69'hB, 1'b0);
    for (int i = 0; i < 3; i++)
      apply_stimulus(1'b0, 1'b0, 1'b1, 4'h6, 69'hDEAD, 1'b0);
    idle(1'b1, 3);

    apply_stimulus(1'b0, 1'b0, 1'b1, 4'h7, 69'h1A, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 4'h7, 69'h1B, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 4'h7, 69'h1C, 1'b0);
    idle(1'b0, 2);
    apply_stimulus(1'b0, 1'b0, 1'b1, 4'h7, 69'h2A, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 4'h7, 69'h2C, 1'b1);
    idle(1'b1, 2);

    apply_stimulus(1'b0, 1'b0, 1'b1, 4'hF, 69'h55, 1'b1);
    idle(1'b1, 4);

    apply_stimulus(1'b0, 1'b0, 1'b1, 4'h9, 69'h77, 1'b0);
    idle(1'b0, 20);
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'h0, 69'h0, 1'b0);
    idle(1'b1, 1);

    for (int i = 0; i < 400; i++) begin
      rnd = {$urandom, $urandom, $urandom};
      apply_stimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
                     1'($urandom_range(0, 1)), 4'($urandom), rnd[68:0],
                     ($urandom_range(0, 3) != 0));
    end
    idle(1'b1, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
